decoder_bank: RTL and testbench
===============================

DECODER_BANK -- requirements
Module: decoder_bank

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in2  input  2  select for both 2-to-4 decoders.
REQ-005 enable  input  1  active-high enable for the basic 2-to-4 and the 3-to-8 decoders.
REQ-006 enable_n  input  1  active-low enable for the active-low 2-to-4 decoder.
REQ-007 in3  input  3  select for the 3-to-8 decoder.
REQ-008 out  output  4  basic 2-to-4 result, active-high one-hot, registered.
REQ-009 out_n  output  4  active-low 2-to-4 result, one-cold, registered.
REQ-010 out8  output  8  3-to-8 result, active-high one-hot, registered.

Function
REQ-011 Basic 2-to-4: next out SHALL be 4'b0001 << in2 when enable=1, else 4'b0000.
REQ-012 Active-low 2-to-4: next out_n SHALL be ~(4'b0001 << in2) when enable_n=0, else 4'b1111.
REQ-013 3-to-8: next out8 SHALL be 8'b0000_0001 << in3 when enable=1, else 8'h00.
REQ-014 Every output SHALL be registered, with a latency of exactly 1 clk cycle from input sample to output.
REQ-015 Outputs SHALL hold stable between rising edges, and no combinational path SHALL exist from any input to any output.
REQ-016 The three decoders SHALL be independent; a change to in3 SHALL NOT affect out or out_n, and a change to in2 SHALL NOT affect out8.
REQ-017 Bit index mapping: out[k] (and out_n[k], out8[k]) SHALL be the line selected by select value k; LSB corresponds to value 0.
REQ-018 enable and enable_n SHALL be sampled separately; the states enable=1/enable_n=1 and enable=0/enable_n=0 are both legal and each decoder SHALL obey only its own enable.
REQ-019 When enabled, out and out8 SHALL each have exactly one bit high, and out_n SHALL have exactly one bit low.

Reset
REQ-020 When rst=1 at a rising edge, the block SHALL load out=4'b0000, out_n=4'b1111 and out8=8'h00, regardless of any other input.
REQ-021 The reset values SHALL be visible on the outputs in the cycle after the reset edge.
REQ-022 Reset asserted mid-operation SHALL override the decode on that edge.
REQ-023 The first edge with rst=0 SHALL load the decoded values of the inputs sampled on that edge.

Configuration
REQ-024 Macro DECODER_BANK_3TO8_EN SHALL control whether the 3-to-8 decoder is built.
REQ-025 With DECODER_BANK_3TO8_EN defined, out8 SHALL behave per REQ-013.
REQ-026 With DECODER_BANK_3TO8_EN undefined, out8 SHALL be constant 8'h00, in3 SHALL be ignored, and no out8 registers SHALL be inferred.
REQ-027 The 2-to-4 paths SHALL be unaffected by the DECODER_BANK_3TO8_EN macro.

Verification
REQ-028 Reset: rst=1 for 2 cycles with arbitrary inputs -> out=0000, out_n=1111, out8=00000000.
REQ-029 Basic and active-low, disabled: enable=0, enable_n=1, in2=00..11 -> out=0000 and out_n=1111 every cycle.
REQ-030 Basic and active-low, enabled: enable=1, enable_n=0, in2=00/01/10/11 -> one cycle later out=0001/0010/0100/1000 and out_n=1110/1101/1011/0111.
REQ-031 3-to-8 sweep: enable=1, in3=000..111 -> one cycle later out8=00000001, 00000010, ... 10000000; enable=0 -> 00000000.
REQ-032 Mixed enables: enable=1, enable_n=1, in2=10 -> out=0100 and out_n=1111; then rst=1 mid-sweep -> reset values on the next cycle.
REQ-033 Macro undefined: in3=101, enable=1 -> out8=00000000 while out=1<<in2 as normal.

Source files
------------

// File: rtl/decoder_bank.sv
// Registered decoder bank: 2-to-4 active-high, 2-to-4 active-low, optional 3-to-8.
// Define DECODER_BANK_3TO8_EN to build the 3-to-8 decoder; otherwise out8 is tied to zero.
module decoder_bank (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] in2,
  input  logic       enable,
  input  logic       enable_n,
  input  logic [2:0] in3,
  output logic [3:0] out,
  output logic [3:0] out_n,
  output logic [7:0] out8
);

  logic [3:0] dec2;

  // One-hot select line per in2 value, shared by both 2-to-4 decoders.
  always_comb begin
    dec2 = 4'b0000;
    for (int k = 0; k < 4; k++)
      dec2[k] = (in2 == 2'(k));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= 4'b0000;
      out_n <= 4'b1111;
    end else begin
      out   <= enable    ? dec2  : 4'b0000;
      out_n <= !enable_n ? ~dec2 : 4'b1111;
    end
  end

`ifdef DECODER_BANK_3TO8_EN
  logic [7:0] dec3;

  always_comb begin
    dec3 = 8'h00;
    for (int k = 0; k < 8; k++)
      dec3[k] = (in3 == 3'(k));
  end

  always_ff @(posedge clk) begin
    if (rst) out8 <= 8'h00;
    else     out8 <= enable ? dec3 : 8'h00;
  end
`else
  logic unused_in3;
  assign unused_in3 = ^in3;
  assign out8       = 8'h00;
`endif

endmodule

// File: tb/tb_decoder_bank.sv
// Self-checking bench for decoder_bank: directed sweeps plus random stimulus
// checked against a power-of-two arithmetic reference model.
module tb_decoder_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in2;
  logic       enable;
  logic       enable_n;
  logic [2:0] in3;
  logic [3:0] out;
  logic [3:0] out_n;
  logic [7:0] out8;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] e_out;
  logic [3:0] e_out_n;
  logic [7:0] e_out8;

  decoder_bank dut (
    .clk(clk), .rst(rst), .in2(in2), .enable(enable), .enable_n(enable_n),
    .in3(in3), .out(out), .out_n(out_n), .out8(out8)
  );

  always #5 clk = ~clk;

  // Reference: what the registers should hold after an edge with these inputs.
  task automatic model(input logic r, input logic e, input logic en_n,
                       input int s2, input int s3);
    int v_out, v_out_n, v_out8;
    if (r) begin
      v_out = 0; v_out_n = 15; v_out8 = 0;
    end else begin
      v_out   = e ? (2 ** s2) : 0;
      v_out_n = en_n ? 15 : 15 - (2 ** s2);
`ifdef DECODER_BANK_3TO8_EN
      v_out8  = e ? (2 ** s3) : 0;
`else
      v_out8  = 0;
`endif
    end
    e_out   = 4'(v_out);
    e_out_n = 4'(v_out_n);
    e_out8  = 8'(v_out8);
  endtask

  // Drive on the falling edge, let one rising edge pass, settle 1 time unit.
  task automatic cycle(input logic r, input logic e, input logic en_n,
                       input logic [1:0] s2, input logic [2:0] s3);
    @(negedge clk);
    rst = r; enable = e; enable_n = en_n; in2 = s2; in3 = s3;
    model(r, e, en_n, int'(s2), int'(s3));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom));
      n_cmp += 3;
      if (out !== 4'b0000) begin n_bad++; $display("FAIL reset_out got=%b want=0000", out); end
      if (out_n !== 4'b1111) begin n_bad++; $display("FAIL reset_out_n got=%b want=1111", out_n); end
      if (out8 !== 8'h00) begin n_bad++; $display("FAIL reset_out8 got=%b want=00000000", out8); end
    end
  endtask

  task automatic test_disabled();
    for (int s = 0; s < 4; s++) begin
      cycle(1'b0, 1'b0, 1'b1, 2'(s), 3'($urandom));
      n_cmp += 3;
      if (out !== 4'b0000) begin n_bad++; $display("FAIL disabled_out in2=%0d got=%b want=0000", s, out); end
      if (out_n !== 4'b1111) begin n_bad++; $display("FAIL disabled_out_n in2=%0d got=%b want=1111", s, out_n); end
      if (out8 !== 8'h00) begin n_bad++; $display("FAIL disabled_out8 got=%b want=00000000", out8); end
    end
  endtask

  task automatic test_enabled();
    logic [3:0] want_out [4]   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] want_out_n [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int s = 0; s < 4; s++) begin
      cycle(1'b0, 1'b1, 1'b0, 2'(s), 3'($urandom));
      n_cmp += 3;
      if (out !== want_out[s]) begin n_bad++; $display("FAIL enabled_out in2=%0d got=%b want=%b", s, out, want_out[s]); end
      if (out_n !== want_out_n[s]) begin n_bad++; $display("FAIL enabled_out_n in2=%0d got=%b want=%b", s, out_n, want_out_n[s]); end
      if (out8 !== e_out8) begin n_bad++; $display("FAIL enabled_out8 got=%b want=%b", out8, e_out8); end
    end
  endtask

  task automatic test_3to8();
    logic [7:0] want;
    for (int s = 0; s < 8; s++) begin
      cycle(1'b0, 1'b1, 1'b1, 2'($urandom), 3'(s));
`ifdef DECODER_BANK_3TO8_EN
      want = 8'h01 << s;
`else
      want = 8'h00;
`endif
      n_cmp += 2;
      if (out8 !== want) begin n_bad++; $display("FAIL sweep_out8 in3=%0d got=%b want=%b", s, out8, want); end
      if (out !== e_out) begin n_bad++; $display("FAIL sweep_out got=%b want=%b", out, e_out); end
    end
    cycle(1'b0, 1'b0, 1'b1, 2'd0, 3'd5);
    n_cmp++;
    if (out8 !== 8'h00) begin n_bad++; $display("FAIL sweep_out8_off got=%b want=00000000", out8); end
  endtask

  task automatic test_mixed();
    cycle(1'b0, 1'b1, 1'b1, 2'b10, 3'b101);
    n_cmp += 3;
    if (out !== 4'b0100) begin n_bad++; $display("FAIL mixed11_out got=%b want=0100", out); end
    if (out_n !== 4'b1111) begin n_bad++; $display("FAIL mixed11_out_n got=%b want=1111", out_n); end
    if (out8 !== e_out8) begin n_bad++; $display("FAIL mixed11_out8 got=%b want=%b", out8, e_out8); end
    cycle(1'b0, 1'b0, 1'b0, 2'b01, 3'b011);
    n_cmp += 3;
    if (out !== 4'b0000) begin n_bad++; $display("FAIL mixed00_out got=%b want=0000", out); end
    if (out_n !== 4'b1101) begin n_bad++; $display("FAIL mixed00_out_n got=%b want=1101", out_n); end
    if (out8 !== 8'h00) begin n_bad++; $display("FAIL mixed00_out8 got=%b want=00000000", out8); end
    // Reset lands mid-sweep with everything enabled.
    cycle(1'b1, 1'b1, 1'b0, 2'b11, 3'b111);
    n_cmp += 3;
    if (out !== 4'b0000) begin n_bad++; $display("FAIL midrst_out got=%b want=0000", out); end
    if (out_n !== 4'b1111) begin n_bad++; $display("FAIL midrst_out_n got=%b want=1111", out_n); end
    if (out8 !== 8'h00) begin n_bad++; $display("FAIL midrst_out8 got=%b want=00000000", out8); end
    // First edge out of reset already decodes.
    cycle(1'b0, 1'b1, 1'b0, 2'b11, 3'b110);
    n_cmp += 3;
    if (out !== 4'b1000) begin n_bad++; $display("FAIL postrst_out got=%b want=1000", out); end
    if (out_n !== 4'b0111) begin n_bad++; $display("FAIL postrst_out_n got=%b want=0111", out_n); end
    if (out8 !== e_out8) begin n_bad++; $display("FAIL postrst_out8 got=%b want=%b", out8, e_out8); end
  endtask

  task automatic test_hold();
    logic [3:0] h_out, h_out_n;
    logic [7:0] h_out8;
    cycle(1'b0, 1'b1, 1'b0, 2'b01, 3'b010);
    h_out = out; h_out_n = out_n; h_out8 = out8;
    // Toggle every input between edges; registered outputs must not move.
    rst = 1'b1; enable = 1'b0; enable_n = 1'b1; in2 = 2'b10; in3 = 3'b111;
    #2;
    n_cmp += 3;
    if (out !== h_out) begin n_bad++; $display("FAIL hold_out got=%b want=%b", out, h_out); end
    if (out_n !== h_out_n) begin n_bad++; $display("FAIL hold_out_n got=%b want=%b", out_n, h_out_n); end
    if (out8 !== h_out8) begin n_bad++; $display("FAIL hold_out8 got=%b want=%b", out8, h_out8); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
            2'($urandom), 3'($urandom));
      n_cmp += 3;
      if (out !== e_out) begin n_bad++; $display("FAIL rand_out it=%0d got=%b want=%b", i, out, e_out); end
      if (out_n !== e_out_n) begin n_bad++; $display("FAIL rand_out_n it=%0d got=%b want=%b", i, out_n, e_out_n); end
      if (out8 !== e_out8) begin n_bad++; $display("FAIL rand_out8 it=%0d got=%b want=%b", i, out8, e_out8); end
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; enable_n = 1'b1; in2 = '0; in3 = '0;
    test_reset();
    test_disabled();
    test_enabled();
    test_3to8();
    test_mixed();
    test_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
